// File: rtl/comparator_seq.sv
// Bit-serial MSB-first magnitude comparator sequencer for the ALU compare path.
// Drives the 1-bit cascade rule over captured operands and reports a registered Z code.
module comparator_seq #(
  parameter int WIDTH      = 4,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       c_in,
  output logic             busy,
  output logic             done,
  output logic [1:0]       z,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [1:0]       q_r;
  logic [IDX_W-1:0] idx_r;
  logic [1:0]       q_upd_s;
  logic             busy_nxt_s;
  logic             done_nxt_s;
  logic             load_res_s;
  logic             busy_r;
  logic             done_r;
  logic [1:0]       z_r;
  logic             gt_r;
  logic             eq_r;
  logic             lt_r;

  // One comparator cell: a decided code holds, otherwise the current bit decides.
  function automatic logic [1:0] cascade_bit(input logic [1:0] q, input logic abit, input logic bbit);
    logic [1:0] r;
    r = q;
    if (q == 2'b00) begin
      if (abit && !bbit) begin
        r = 2'b10;
      end else if (!abit && bbit) begin
        r = 2'b01;
      end else begin
        r = 2'b00;
      end
    end else begin
      r = q;
    end
    return r;
  endfunction

  // Working code after applying the cell to the current bit.
  always_comb begin
    q_upd_s = cascade_bit(q_r, a_r[idx_r], b_r[idx_r]);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; DONE always lasts one cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if ((idx_r == IDX_W'(0)) || (EARLY_EXIT && (q_upd_s != 2'b00))) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode: next values of the registered outputs.
  always_comb begin
    busy_nxt_s = (state_nxt_s != IDLE);
    done_nxt_s = (state_nxt_s == DONE);
    load_res_s = (state_r == RUN) && (state_nxt_s == DONE);
  end

  // Operand capture, bit walk and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      q_r    <= 2'b00;
      idx_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      z_r    <= 2'b00;
      gt_r   <= 1'b0;
      eq_r   <= 1'b1;
      lt_r   <= 1'b0;
    end else begin
      if ((state_r == IDLE) && start) begin
        a_r   <= a;
        b_r   <= b;
        q_r   <= (c_in == 2'b11) ? 2'b00 : c_in;
        idx_r <= IDX_W'(WIDTH - 1);
      end else if (state_r == RUN) begin
        q_r <= q_upd_s;
        if (idx_r != IDX_W'(0)) begin
          idx_r <= idx_r - IDX_W'(1);
        end else begin
          idx_r <= idx_r;
        end
      end else begin
        q_r <= q_r;
      end
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
      if (load_res_s) begin
        z_r  <= q_upd_s;
        gt_r <= (q_upd_s == 2'b10);
        eq_r <= (q_upd_s == 2'b00);
        lt_r <= (q_upd_s == 2'b01);
      end else begin
        z_r <= z_r;
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign z    = z_r;
  assign gt   = gt_r;
  assign eq   = eq_r;
  assign lt   = lt_r;

endmodule

// File: tb/tb_comparator_seq.sv
// Randomised and directed bench for comparator_seq against a latency/result model.
// Three instances: WIDTH=4 EARLY_EXIT=0, WIDTH=4 EARLY_EXIT=1, WIDTH=1 EARLY_EXIT=0.
module tb_comparator_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] c_in;

  logic       busy_v [3];
  logic       done_v [3];
  logic [1:0] z_v    [3];
  logic       gt_v   [3];
  logic       eq_v   [3];
  logic       lt_v   [3];

  int n_chk;
  int n_fail;

  comparator_seq #(.WIDTH(4), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c_in(c_in),
    .busy(busy_v[0]), .done(done_v[0]), .z(z_v[0]), .gt(gt_v[0]), .eq(eq_v[0]), .lt(lt_v[0]));

  comparator_seq #(.WIDTH(4), .EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c_in(c_in),
    .busy(busy_v[1]), .done(done_v[1]), .z(z_v[1]), .gt(gt_v[1]), .eq(eq_v[1]), .lt(lt_v[1]));

  comparator_seq #(.WIDTH(1), .EARLY_EXIT(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a[0:0]), .b(b[0:0]), .c_in(c_in),
    .busy(busy_v[2]), .done(done_v[2]), .z(z_v[2]), .gt(gt_v[2]), .eq(eq_v[2]), .lt(lt_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected result from plain integer compare of the instance's operand width.
  function automatic logic [1:0] exp_res(input int k, input logic [3:0] ta, input logic [3:0] tb_, input logic [1:0] tc);
    int w;
    int av;
    int bv;
    w = (k == 2) ? 1 : 4;
    if (tc == 2'b01 || tc == 2'b10) return tc;
    av = int'(ta) % (1 << w);
    bv = int'(tb_) % (1 << w);
    if (av > bv) return 2'b10;
    if (av < bv) return 2'b01;
    return 2'b00;
  endfunction

  // Expected cycles from accept edge to done.
  function automatic int exp_lat(input int k, input logic [3:0] ta, input logic [3:0] tb_, input logic [1:0] tc);
    int w;
    w = (k == 2) ? 1 : 4;
    if (k != 1) return w;
    if (tc == 2'b01 || tc == 2'b10) return 1;
    for (int i = w - 1; i >= 0; i--) begin
      if (ta[i] != tb_[i]) return w - i;
    end
    return w;
  endfunction

  logic       m_busy [3];
  int         m_cnt  [3];
  int         m_lat  [3];
  logic [1:0] m_res  [3];
  logic [1:0] m_z    [3];

  // Reference model: a pending request counts cycles until its latency expires.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_busy[k] <= 1'b0;
        m_cnt[k]  <= 0;
        m_lat[k]  <= 0;
        m_res[k]  <= 2'b00;
        m_z[k]    <= 2'b00;
      end else if (!m_busy[k]) begin
        if (start) begin
          m_busy[k] <= 1'b1;
          m_cnt[k]  <= 0;
          m_lat[k]  <= exp_lat(k, a, b, c_in);
          m_res[k]  <= exp_res(k, a, b, c_in);
        end
      end else begin
        m_cnt[k] <= m_cnt[k] + 1;
        if (m_cnt[k] + 1 == m_lat[k]) m_z[k] <= m_res[k];
        if (m_cnt[k] == m_lat[k]) m_busy[k] <= 1'b0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dut%0d_outs", k),
          {25'd0, busy_v[k], done_v[k], z_v[k], gt_v[k], eq_v[k], lt_v[k]},
          {25'd0, m_busy[k], (m_busy[k] && (m_cnt[k] == m_lat[k])), m_z[k],
           (m_z[k] == 2'b10), (m_z[k] == 2'b00), (m_z[k] == 2'b01)});
    end
  end

  task automatic run_op(input string nm, input logic [3:0] ta, input logic [3:0] tb_, input logic [1:0] tc,
                        input int lat0, input int lat1, input logic [1:0] zexp);
    int d0;
    int d1;
    int nb0;
    logic [1:0] z0;
    logic [1:0] z1;
    d0 = -1; d1 = -1; nb0 = 0; z0 = 2'b11; z1 = 2'b11;
    @(negedge clk);
    a = ta; b = tb_; c_in = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 4'($urandom); b = 4'($urandom); c_in = 2'($urandom);
    for (int t = 0; t < 12; t++) begin
      if (t > 0) @(negedge clk);
      if (busy_v[0]) nb0++;
      if (done_v[0] && d0 < 0) begin d0 = t; z0 = z_v[0]; end
      if (done_v[1] && d1 < 0) begin d1 = t; z1 = z_v[1]; end
    end
    chk({nm, "_lat_ee0"}, d0, lat0);
    chk({nm, "_lat_ee1"}, d1, lat1);
    chk({nm, "_z_ee0"}, {30'd0, z0}, {30'd0, zexp});
    chk({nm, "_z_ee1"}, {30'd0, z1}, {30'd0, zexp});
    chk({nm, "_busy_cycles"}, nb0, lat0 + 1);
  endtask

  initial begin
    int ndone;
    int dfirst;
    int dsecond;
    int d1second;
    logic [1:0] zfirst;
    logic any_busy;
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b1; a = 4'd0; b = 4'd0; c_in = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy_v[0]}, 32'd0);
    chk("reset_done", {31'd0, done_v[0]}, 32'd0);
    chk("reset_z", {30'd0, z_v[0]}, 32'd0);
    chk("reset_eq", {31'd0, eq_v[0]}, 32'd1);
    start = 1'b0;
    #1 rst_n = 1'b1;

    run_op("eq1010",  4'b1010, 4'b1010, 2'b00, 4, 4, 2'b00);
    run_op("gt_msb",  4'b1010, 4'b0010, 2'b00, 4, 1, 2'b10);
    run_op("lt_lsb",  4'b0110, 4'b0111, 2'b00, 4, 4, 2'b01);
    run_op("casc01",  4'b1111, 4'b0000, 2'b01, 4, 1, 2'b01);
    run_op("casc11",  4'b0101, 4'b0101, 2'b11, 4, 4, 2'b00);

    // Start pulses while busy are dropped; restart lands on the first idle cycle.
    ndone = 0; dfirst = -1; dsecond = -1; d1second = -1; zfirst = 2'b11;
    @(negedge clk);
    a = 4'b0001; b = 4'b0000; c_in = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 4'b1111; b = 4'b0000;
    for (int t = 0; t < 15; t++) begin
      if (t > 0) @(negedge clk);
      if (done_v[0] && t <= 5) begin
        ndone++;
        if (dfirst < 0) begin dfirst = t; zfirst = z_v[0]; end
      end
      if (done_v[0] && t > 5 && dsecond < 0) dsecond = t;
      if (done_v[1] && t > 5 && d1second < 0) d1second = t;
      start = (t == 1 || t == 3 || t == 4 || t == 5);
    end
    chk("busy_single_done", ndone, 1);
    chk("busy_done_edge", dfirst, 4);
    chk("busy_first_z", {30'd0, zfirst}, 32'd2);
    chk("restart_ee0", dsecond, 10);
    chk("restart_ee1", d1second, 7);

    // Reset in the middle of a run discards the request.
    @(negedge clk);
    a = 4'b0100; b = 4'b0011; c_in = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy_v[0]}, 32'd0);
    chk("midrst_z", {30'd0, z_v[0]}, 32'd0);
    #1 rst_n = 1'b1;
    ndone = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (done_v[0]) ndone++;
    end
    chk("midrst_no_done", ndone, 0);

    // Exhaustive a/b sweep with a legal equal cascade code.
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      a = 4'(i >> 4); b = 4'(i); c_in = 2'b00; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      any_busy = 1'b1;
      for (int g = 0; g < 12 && any_busy; g++) begin
        @(negedge clk);
        any_busy = busy_v[0] | busy_v[1] | busy_v[2];
      end
      if (any_busy) chk("sweep_idle_timeout", {31'd0, any_busy}, 32'd0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Random traffic including illegal cascade codes and starts while busy.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      a = 4'($urandom); b = 4'($urandom); c_in = 2'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/comparator_seq.md
Name: comparator_seq

Overview:
- Bit-serial magnitude comparator sequencer for the 4-bit ALU compare path.
- Accepts two WIDTH-bit operands and a cascade code on a start pulse.
- Walks the operands MSB-first, one bit per clock, applying the same 1-bit cascade rule as the combinational comparator cell.
- Returns a registered 2-bit result code (Z1 Z0) plus decoded gt/eq/lt flags with a one-cycle done pulse. It is the driving (initiator) end of the comparator cascade: it generates the per-bit A/B/C sequence and consumes the Z codes.

Parameters:
- WIDTH, 4, operand width in bits; legal range 1..16.
- EARLY_EXIT, 1, 1 = finish on the first unequal bit; 0 = always process all WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A, captured when start is accepted.
- b  input  WIDTH  operand B, captured when start is accepted.
- c_in  input  2  cascade code from a more-significant stage, captured when start is accepted: {C1,C0}.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; result is valid in this cycle.
- z  output  2  result code {Z1,Z0}: 00 = equal, 10 = A>B, 01 = A<B.
- gt  output  1  z==10.
- eq  output  1  z==00.
- lt  output  1  z==01.

Behaviour:
- One clock domain; rst_n is asynchronous assert, synchronous deassert is the integrator's responsibility.
- Reset values:
  - state=IDLE; busy=0; done=0; z=00; gt=0; eq=1; lt=0.
  - Internal operand/index registers cleared.
- Cascade code values: 00 = equal so far, 10 = A greater, 01 = A less. An input code of 11 is illegal and is treated as 00 on capture.
- Per-bit rule, applied to code q and bit i:
  - if q!=00, q holds;
  - else if a[i]=1 and b[i]=0, q=10;
  - else if a[i]=0 and b[i]=1, q=01;
  - else q=00.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1, capture a, b, c_in (11 becomes 00) into the working code q, set idx=WIDTH-1, and go to RUN.
  - start=0: stay.
- RUN, one bit per cycle:
  - At each edge, apply the rule to bit idx and decrement idx.
  - Go to DONE when idx==0 was just processed.
  - If EARLY_EXIT=1, also go to DONE on the edge where the updated q!=00.
  - If EARLY_EXIT=1 and the captured c_in!=00, exactly one RUN cycle occurs and the code is passed through unchanged.
- DONE: done=1 for exactly one cycle; unconditionally return to IDLE on the next edge.
- Outputs z/gt/eq/lt are registered together with the DONE transition. They change only on entry to DONE and hold until the next DONE or reset; they do not change while RUN is in progress.
- Latency, with the start-accept edge as edge 0:
  - EARLY_EXIT=0: done is high after edge WIDTH.
  - EARLY_EXIT=1: first mismatch at bit i gives done after edge WIDTH-i; an all-equal compare still takes WIDTH.
- start while busy (RUN or DONE) is ignored. It is not queued, and the captured operands do not change.
- start in the same cycle that DONE is exiting is ignored. The earliest accepted restart is the edge after done falls, i.e. the first IDLE cycle.
- Operand inputs a/b/c_in may change freely after the accept edge without affecting the result.
- Reset asserted mid-RUN or in DONE: immediately return to the reset values; the pending result is discarded and no done is produced.
- WIDTH=1: a single RUN cycle; done after edge 1.

Test Plan:
1. Reset with EARLY_EXIT=0, WIDTH=4: assert rst_n=0 with start=1 -> busy=0, done=0, z=00, eq=1. Release reset, then start with a=1010, b=1010, c_in=00 -> done after edge 4, z=00, eq=1, busy high for 5 cycles.
2. EARLY_EXIT=1: a=1010, b=0010 -> done after edge 1, z=10, gt=1. Then a=0110, b=0111 -> done after edge 4, z=01, lt=1.
3. Cascade input: c_in=01 with a=1111, b=0000, EARLY_EXIT=1 -> done after edge 1, z=01. c_in=11 with a=b=0101 -> treated as 00, done after edge 4, z=00.
4. Busy protection: start with a=0001, b=0000; pulse start at edges 2 and 4 with a=1111, b=0000 -> single done after edge 4, z=10 from the first operands. Restart accepted only at the first IDLE cycle (after edge 5).
5. Reset mid-operation: start a=0100, b=0011 with EARLY_EXIT=0; drop rst_n between edges 2 and 3 -> busy=0, z=00, and no done pulse ever appears for that request.
6. Exhaustive sweep, WIDTH=4, both EARLY_EXIT values, all 256 a/b pairs with c_in=00 -> z matches the integer compare, exactly one done pulse per start, gt/eq/lt one-hot.
